pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline with precise exceptions. It drives enable/clear/IntReg controls for the F/D, D/E, E/M and M/W pipeline registers and the PC next-address select. It owns the mult/div busy timer and the exception-entry/ERET sequencing FSM. It sits beside the hazard comparator and CP0, between those units and every pipeline register.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_hazard_ctrl_md_busy_timer.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXC       = 2'd1,
    ERET_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_VEC = 2'd1;
  localparam logic [1:0] PC_SEL_EPC = 2'd2;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  function automatic int max_cyc(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard comparator/CP0 side and the pipeline sequencer.
// Optional perf counter outputs appear when PIPE_CTRL_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  logic       data_stall_D;
  logic       md_start_E;
  logic       md_is_div_E;
  logic       md_use_D;
  logic       exc_take_M;
  logic       eret_D;
  logic       epc_pending;
  logic       PC_En;
  logic       F_D_En;
  logic       F_D_Clr;
  logic       D_E_Clr;
  logic       E_M_Clr;
  logic       M_W_Clr;
  logic       IntReg;
  logic [1:0] pc_sel;
  logic       md_busy;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_md;
  logic [31:0] perf_exc;
`endif

  modport master (
    output data_stall_D, md_start_E, md_is_div_E, md_use_D,
           exc_take_M, eret_D, epc_pending,
    input  PC_En, F_D_En, F_D_Clr, D_E_Clr, E_M_Clr, M_W_Clr,
           IntReg, pc_sel, md_busy, state_o
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall, perf_md, perf_exc
`endif
  );

  modport slave (
    input  data_stall_D, md_start_E, md_is_div_E, md_use_D,
           exc_take_M, eret_D, epc_pending,
    output PC_En, F_D_En, F_D_Clr, D_E_Clr, E_M_Clr, M_W_Clr,
           IntReg, pc_sel, md_busy, state_o
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall, perf_md, perf_exc
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// HI/LO busy timer: loads the mult/div latency, counts down to zero, and can be cancelled.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic md_busy
);

  localparam int TW = $clog2(max_cyc(MULT_CYC, DIV_CYC) + 1);
  // The start cycle itself is busy via the start term, so the counter holds the remaining N-1.
  localparam logic [TW-1:0] MULT_LOAD = TW'(MULT_CYC - 1);
  localparam logic [TW-1:0] DIV_LOAD  = TW'(DIV_CYC - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (cancel) begin
      timer <= '0;
    end else if (start) begin
      timer <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  assign md_busy = (timer != '0) | (start & ~cancel);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: pipeline-register controls, PC select, exception/ERET FSM.
// Define PIPE_CTRL_PERF_EN to add saturating stall/md-stall/exception event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  state_t state, state_next;
  logic   md_busy;
  logic   md_stall;
  logic   stall;
  logic   run_stall;

  // A start that coincides with an exception belongs to a killed instruction.
  md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.md_start_E & ~bus.exc_take_M),
    .is_div  (bus.md_is_div_E),
    .cancel  (state == EXC),
    .md_busy (md_busy)
  );

  assign md_stall = bus.md_use_D & md_busy;
  assign stall    = bus.data_stall_D | md_stall | (bus.eret_D & bus.epc_pending);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.PC_En   = 1'b1;
    bus.F_D_En  = 1'b1;
    bus.F_D_Clr = 1'b0;
    bus.D_E_Clr = 1'b0;
    bus.E_M_Clr = 1'b0;
    bus.M_W_Clr = 1'b0;
    bus.IntReg  = 1'b0;
    bus.pc_sel  = PC_SEL_SEQ;
    run_stall   = 1'b0;

    case (state)
      RUN: begin
        if (stall) begin
          run_stall   = 1'b1;
          bus.PC_En   = 1'b0;
          bus.F_D_En  = 1'b0;
          bus.D_E_Clr = 1'b1;
        end else if (bus.eret_D) begin
          bus.pc_sel  = PC_SEL_EPC;
          bus.F_D_Clr = 1'b1;
          state_next  = ERET_HOLD;
        end
      end
      EXC: begin
        bus.F_D_Clr = 1'b1;
        state_next  = RUN;
      end
      ERET_HOLD: begin
        if (stall) begin
          bus.PC_En   = 1'b0;
          bus.F_D_En  = 1'b0;
          bus.D_E_Clr = 1'b1;
        end
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // Exception entry overrides any stall or eret in every state.
    if (bus.exc_take_M) begin
      run_stall   = 1'b0;
      bus.PC_En   = 1'b1;
      bus.F_D_En  = 1'b1;
      bus.F_D_Clr = 1'b1;
      bus.D_E_Clr = 1'b0;
      bus.E_M_Clr = 1'b1;
      bus.M_W_Clr = 1'b0;
      bus.IntReg  = 1'b1;
      bus.pc_sel  = PC_SEL_VEC;
      state_next  = EXC;
    end
  end

  assign bus.md_busy = md_busy;
  assign bus.state_o = state;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt, exc_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
      exc_cnt      <= '0;
    end else begin
      if (run_stall && stall_cnt != '1)              stall_cnt    <= stall_cnt + 1'b1;
      if (run_stall && md_stall && md_stall_cnt != '1) md_stall_cnt <= md_stall_cnt + 1'b1;
      if (bus.exc_take_M && exc_cnt != '1)           exc_cnt      <= exc_cnt + 1'b1;
    end
  end

  assign bus.perf_stall = stall_cnt;
  assign bus.perf_md    = md_stall_cnt;
  assign bus.perf_exc   = exc_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences, scoreboard-checked.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stim order: {data_stall_D, md_start_E, md_is_div_E, md_use_D, exc_take_M, eret_D, epc_pending}
  typedef struct {
    string      name;
    logic [6:0] stim;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  fails  = 0;

  // Expected word: {PC_En,F_D_En,F_D_Clr,D_E_Clr,E_M_Clr,M_W_Clr,IntReg,pc_sel,md_busy,state_o}
  function automatic logic [11:0] ex(bit pe, bit fe, bit fc, bit dc, bit ec, bit mc, bit ir,
                                     logic [1:0] ps, bit mb, logic [1:0] st);
    return {pe, fe, fc, dc, ec, mc, ir, ps, mb, st};
  endfunction

  function automatic logic [11:0] actual();
    return {bus.PC_En, bus.F_D_En, bus.F_D_Clr, bus.D_E_Clr, bus.E_M_Clr, bus.M_W_Clr,
            bus.IntReg, bus.pc_sel, bus.md_busy, bus.state_o};
  endfunction

  task automatic drive(input logic [6:0] s);
    {bus.data_stall_D, bus.md_start_E, bus.md_is_div_E, bus.md_use_D,
     bus.exc_take_M, bus.eret_D, bus.epc_pending} = s;
  endtask

  task automatic expectNow(input string nm, input logic [11:0] e);
    sb_t item;
    item.name = nm;
    item.exp  = e;
    sbq.push_back(item);
  endtask

  task automatic applyStimulus(input string nm, input logic [6:0] s, input logic [11:0] e);
    @(posedge clk);
    #1;
    drive(s);
    expectNow(nm, e);
  endtask

  task automatic checkOutput();
    sb_t item;
    logic [11:0] a;
    checks++;
    a = actual();
    if (sbq.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_empty: got %b, no expected entry", a);
    end else begin
      item = sbq.pop_front();
      if (a !== item.exp) begin
        fails++;
        $display("[TB] FAIL %s: got %b required %b (PCEn,FDEn,FDClr,DEClr,EMClr,MWClr,IntReg,pcsel,busy,state)",
                 item.name, a, item.exp);
      end
    end
  endtask

  task automatic step(input string nm, input logic [6:0] s, input logic [11:0] e);
    applyStimulus(nm, s, e);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    drive(7'b0);
    repeat (n) @(posedge clk);
  endtask

  vec_t vecs[12];
  logic [11:0] IDLE0, STALL0, STALL1;

  initial begin
    IDLE0  = ex(1,1,0,0,0,0,0,2'd0,0,2'd0);
    STALL0 = ex(0,0,0,1,0,0,0,2'd0,0,2'd0);
    STALL1 = ex(0,0,0,1,0,0,0,2'd0,1,2'd0);

    vecs[0]  = '{"idle",            7'b0000000, IDLE0};
    vecs[1]  = '{"data_stall",      7'b1000000, STALL0};
    vecs[2]  = '{"md_use_notbusy",  7'b0001000, IDLE0};
    vecs[3]  = '{"md_start_use",    7'b0101000, STALL1};
    vecs[4]  = '{"eret_epc_pend",   7'b0000011, STALL0};
    vecs[5]  = '{"eret_clean",      7'b0000010, ex(1,1,1,0,0,0,0,2'd2,0,2'd0)};
    vecs[6]  = '{"exc_alone",       7'b0000100, ex(1,1,1,0,1,0,1,2'd1,0,2'd0)};
    vecs[7]  = '{"exc_over_all",    7'b1000110, ex(1,1,1,0,1,0,1,2'd1,0,2'd0)};
    vecs[8]  = '{"exc_kills_start", 7'b0110100, ex(1,1,1,0,1,0,1,2'd1,0,2'd0)};
    vecs[9]  = '{"md_start_only",   7'b0100000, ex(1,1,0,0,0,0,0,2'd0,1,2'd0)};
    vecs[10] = '{"eret_and_stall",  7'b1000010, STALL0};
    vecs[11] = '{"md_stall_eret",   7'b0101010, STALL1};

    reset = 1'b0;
    drive(7'b0);
    #2;
    expectNow("reset_state", IDLE0);
    checkOutput();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].stim, vecs[i].exp);
      idle(12);
    end

    // Divide latency with a dependent HI/LO reader held in D.
    step("div_c0", 7'b0111000, STALL1);
    for (int k = 1; k < 10; k++) step($sformatf("div_c%0d", k), 7'b0001000, STALL1);
    step("div_c10", 7'b0001000, IDLE0);
    idle(2);

    // Two-cycle RAW stall then release.
    step("raw_c0", 7'b1000000, STALL0);
    step("raw_c1", 7'b1000000, STALL0);
    step("raw_c2", 7'b0000000, IDLE0);
    idle(2);

    // Exception overriding stall and eret, then EXC, then RUN.
    step("exc_c0", 7'b1000110, ex(1,1,1,0,1,0,1,2'd1,0,2'd0));
    step("exc_c1", 7'b0000000, ex(1,1,1,0,0,0,0,2'd0,0,2'd1));
    step("exc_c2", 7'b0000000, IDLE0);
    idle(2);

    // Exception while a mult is counting cancels the timer.
    step("mexc_c0", 7'b0100000, ex(1,1,0,0,0,0,0,2'd0,1,2'd0));
    step("mexc_c1", 7'b0000000, ex(1,1,0,0,0,0,0,2'd0,1,2'd0));
    step("mexc_c2", 7'b0000100, ex(1,1,1,0,1,0,1,2'd1,1,2'd0));
    step("mexc_c3", 7'b0000000, ex(1,1,1,0,0,0,0,2'd0,1,2'd1));
    step("mexc_c4", 7'b0000000, IDLE0);
    idle(2);

    // ERET waits for the EPC write, then redirects and holds one cycle.
    step("eret_c0", 7'b0000011, STALL0);
    step("eret_c1", 7'b0000011, STALL0);
    step("eret_c2", 7'b0000010, ex(1,1,1,0,0,0,0,2'd2,0,2'd0));
    step("eret_c3", 7'b0000000, ex(1,1,0,0,0,0,0,2'd0,0,2'd2));
    step("eret_c4", 7'b0000000, IDLE0);
    idle(2);

    // Asynchronous reset in the middle of a divide count.
    step("rst_c0", 7'b0110000, ex(1,1,0,0,0,0,0,2'd0,1,2'd0));
    step("rst_c1", 7'b0000000, ex(1,1,0,0,0,0,0,2'd0,1,2'd0));
    step("rst_c2", 7'b0000000, ex(1,1,0,0,0,0,0,2'd0,1,2'd0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    expectNow("rst_midcount", IDLE0);
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Asynchronous reset while in EXC.
    step("rstx_c0", 7'b0000100, ex(1,1,1,0,1,0,1,2'd1,0,2'd0));
    @(posedge clk);
    #1;
    drive(7'b0);
    #1;
    reset = 1'b0;
    #1;
    expectNow("rst_in_exc", IDLE0);
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    step("post_reset_idle", 7'b0000000, IDLE0);

    if (sbq.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
